// File: rtl/coin_sprite_loader.sv
// Coin sprite RAM writer: turns a valid/ready pixel stream into row-major sprite RAM
// writes for one animation frame per load (IDLE -> LOAD -> DONE -> IDLE).
module coin_sprite_loader #(
    parameter int SPR_W   = 15,
    parameter int SPR_H   = 20,
    parameter int PIX_W   = 8,
    parameter int ADDR_W  = 19,
    parameter int FRAME_W = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] frame_sel,
    input  logic [PIX_W-1:0]   data_in,
    input  logic               data_valid,
    output logic               ready,
    output logic               we,
    output logic [ADDR_W-1:0]  write_addr,
    output logic [PIX_W-1:0]   write_data,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);
    // Handshake: a pixel is taken on a rising edge where data_valid && ready && !abort
    // in LOAD; its RAM write (we/write_addr/write_data) appears on the following cycle.

    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = $clog2(SPR_H + 1);

    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(SPR_H - 1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_write_addr;
    logic [PIX_W-1:0]  r_write_data;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;

    logic [ADDR_W-1:0] w_base;
    logic              w_accept;
    logic              w_last_beat;

    always_comb begin
        w_base      = {{(ADDR_W - FRAME_W){1'b0}}, frame_sel} * FRAME_SIZE;
        w_accept    = (r_state == S_LOAD) && data_valid && r_ready && !abort;
        w_last_beat = (r_col == LAST_COL) && (r_row == LAST_ROW);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_we         <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_col        <= '0;
            r_row        <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_addr  <= w_base;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        r_we         <= 1'b1;
                        r_write_addr <= r_addr;
                        r_write_data <= data_in;
                        r_addr       <= r_addr + ADDR_W'(1);
                        // addr always equals base + col + row*SPR_W
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (w_last_beat) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign we         = r_we;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_coin_sprite_loader.sv
// Bench for coin_sprite_loader: randomized pixel streams against a frame/offset
// address model, with a write scoreboard fed from an expected queue.
module tb_coin_sprite_loader;
    localparam int SPR_W   = 15;
    localparam int SPR_H   = 20;
    localparam int PIX_W   = 8;
    localparam int ADDR_W  = 19;
    localparam int FRAME_W = 2;
    localparam int NPIX    = SPR_W * SPR_H;
    localparam int W       = ADDR_W + PIX_W;

    logic               Clk;
    logic               Reset_n;
    logic               start;
    logic               abort;
    logic [FRAME_W-1:0] frame_sel;
    logic [PIX_W-1:0]   data_in;
    logic               data_valid;
    logic               ready;
    logic               we;
    logic [ADDR_W-1:0]  write_addr;
    logic [PIX_W-1:0]   write_data;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    coin_sprite_loader #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .FRAME_W(FRAME_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
        .frame_sel(frame_sel), .data_in(data_in), .data_valid(data_valid),
        .ready(ready), .we(we), .write_addr(write_addr), .write_data(write_data),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           obs_addr_q[$];
    int           wr_cnt;
    int           done_cnt;
    int           done_cyc;
    int           model_last_cyc;
    logic [W-1:0] exp_w;
    int           exp_c;

    always @(negedge Clk) begin
        if (we) begin
            wr_cnt++;
            obs_addr_q.push_back(int'(write_addr));
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got addr %0d data %0h, expected no write",
                         write_addr, write_data);
            end else begin
                exp_w = exp_q.pop_front();
                exp_c = exp_cyc_q.pop_front();
                if ({write_addr, write_data} !== exp_w || cyc != exp_c)
                    $display("FAIL sb_write: got addr %0d data %0h cyc %0d, expected addr %0d data %0h cyc %0d",
                             write_addr, write_data, cyc, exp_w[W-1:PIX_W], exp_w[PIX_W-1:0], exp_c);
                else
                    n_pass++;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        exp_cyc_q.delete();
        obs_addr_q.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    // driver: mode 0 = continuous valid (data = addr[7:0]), 1 = 1010 toggle, 2 = random
    task automatic drive_load(input int frame, input int mode, input int abort_beat,
                              input bit start_in_load, input int max_beats,
                              output int cycles, output int accepted);
        int base;
        int a;
        base = frame * NPIX;
        @(negedge Clk);
        start      = 1'b1;
        abort      = 1'b0;
        frame_sel  = FRAME_W'(frame);
        data_valid = 1'b0;
        @(negedge Clk);
        start    = 1'b0;
        accepted = 0;
        cycles   = 0;
        while (accepted < max_beats && cycles < 2000) begin
            a = base + accepted;
            case (mode)
                0:       data_valid = 1'b1;
                1:       data_valid = (cycles % 2 == 0);
                default: data_valid = 1'($urandom_range(0, 1));
            endcase
            data_in = (mode == 0) ? PIX_W'(a) : PIX_W'($urandom);
            if (start_in_load) begin
                start     = 1'($urandom_range(0, 1));
                frame_sel = FRAME_W'($urandom);
            end
            abort = (abort_beat != 0) && data_valid && (accepted == abort_beat - 1);
            if (data_valid && ready && !abort) begin
                exp_q.push_back({ADDR_W'(a), data_in});
                exp_cyc_q.push_back(cyc + 1);
                model_last_cyc = cyc + 1;
                accepted++;
            end
            @(negedge Clk);
            cycles++;
            if (abort) break;
        end
        start      = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        frame_sel  = '0;
        data_in    = '0;
        data_valid = 1'b0;
        idle_cycles(3);
        n_checks++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", ready); else n_pass++;
        n_checks++; if (we !== 1'b0) $display("FAIL rst_we: got %b expected 0", we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (write_addr !== '0) $display("FAIL rst_addr: got %0d expected 0", write_addr); else n_pass++;
        n_checks++; if (write_data !== '0) $display("FAIL rst_data: got %0h expected 0", write_data); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL rst_state: got %0d expected 0", state_dbg); else n_pass++;
        Reset_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_frame0_stream();
        int cycles, acc;
        clear_sb();
        drive_load(0, 0, 0, 1'b0, NPIX, cycles, acc);
        idle_cycles(4);
        n_checks++; if (wr_cnt != NPIX) $display("FAIL f0_writes: got %0d expected %0d", wr_cnt, NPIX); else n_pass++;
        n_checks++; if (cycles != NPIX) $display("FAIL f0_no_bubbles: got %0d cycles expected %0d", cycles, NPIX); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL f0_missing: got %0d pending expected 0", exp_q.size()); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL f0_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (done_cyc != model_last_cyc + 1) $display("FAIL f0_done_cycle: got %0d expected %0d", done_cyc, model_last_cyc + 1); else n_pass++;
        n_checks++; if (obs_addr_q[NPIX-1] != NPIX - 1) $display("FAIL f0_last_addr: got %0d expected %0d", obs_addr_q[NPIX-1], NPIX - 1); else n_pass++;
    endtask

    task automatic test_frame2_rows();
        int cycles, acc;
        clear_sb();
        drive_load(2, 2, 0, 1'b0, NPIX, cycles, acc);
        idle_cycles(4);
        n_checks++; if (wr_cnt != NPIX) $display("FAIL f2_writes: got %0d expected %0d", wr_cnt, NPIX); else n_pass++;
        n_checks++; if (obs_addr_q[0] != 600) $display("FAIL f2_first_addr: got %0d expected 600", obs_addr_q[0]); else n_pass++;
        n_checks++; if (obs_addr_q[14] != 614) $display("FAIL f2_beat14: got %0d expected 614", obs_addr_q[14]); else n_pass++;
        n_checks++; if (obs_addr_q[15] != 615) $display("FAIL f2_beat15: got %0d expected 615", obs_addr_q[15]); else n_pass++;
        n_checks++; if (obs_addr_q[NPIX-1] != 899) $display("FAIL f2_last_addr: got %0d expected 899", obs_addr_q[NPIX-1]); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL f2_done_count: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_toggle_valid();
        int cycles, acc;
        clear_sb();
        drive_load(3, 1, 0, 1'b0, NPIX, cycles, acc);
        idle_cycles(4);
        n_checks++; if (wr_cnt != NPIX) $display("FAIL tog_writes: got %0d expected %0d", wr_cnt, NPIX); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL tog_missing: got %0d pending expected 0", exp_q.size()); else n_pass++;
        n_checks++; if (obs_addr_q[NPIX-1] != 1199) $display("FAIL tog_last_addr: got %0d expected 1199", obs_addr_q[NPIX-1]); else n_pass++;
        n_checks++; if (done_cyc != model_last_cyc + 1) $display("FAIL tog_done_cycle: got %0d expected %0d", done_cyc, model_last_cyc + 1); else n_pass++;
    endtask

    task automatic test_abort();
        int cycles, acc;
        clear_sb();
        drive_load(0, 0, 100, 1'b0, NPIX, cycles, acc);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", ready); else n_pass++;
        idle_cycles(5);
        n_checks++; if (wr_cnt != 99) $display("FAIL abort_writes: got %0d expected 99", wr_cnt); else n_pass++;
        n_checks++; if (obs_addr_q[98] != 98) $display("FAIL abort_last_addr: got %0d expected 98", obs_addr_q[98]); else n_pass++;
        n_checks++; if (done_cnt != 0) $display("FAIL abort_done: got %0d expected 0", done_cnt); else n_pass++;
        clear_sb();
        drive_load(0, 2, 0, 1'b0, NPIX, cycles, acc);
        idle_cycles(4);
        n_checks++; if (obs_addr_q[0] != 0) $display("FAIL abort_reload_first: got %0d expected 0", obs_addr_q[0]); else n_pass++;
        n_checks++; if (wr_cnt != NPIX) $display("FAIL abort_reload_writes: got %0d expected %0d", wr_cnt, NPIX); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int cycles, acc;
        clear_sb();
        @(negedge Clk);
        start = 1'b1;
        abort = 1'b1;
        data_valid = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL sa_idle_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL sa_idle_ready: got %b expected 0", ready); else n_pass++;
        idle_cycles(3);
        data_valid = 1'b0;
        n_checks++; if (wr_cnt != 0) $display("FAIL sa_idle_writes: got %0d expected 0", wr_cnt); else n_pass++;
        drive_load(1, 0, 0, 1'b1, NPIX, cycles, acc);
        idle_cycles(4);
        n_checks++; if (wr_cnt != NPIX) $display("FAIL sil_writes: got %0d expected %0d", wr_cnt, NPIX); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL sil_missing: got %0d pending expected 0", exp_q.size()); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL sil_done_count: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int cycles, acc;
        int rdy_seen;
        clear_sb();
        drive_load(2, 0, 0, 1'b0, 50, cycles, acc);
        #2 Reset_n = 1'b0;
        #1;
        n_checks++; if (we !== 1'b0) $display("FAIL mrst_we: got %b expected 0", we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL mrst_ready: got %b expected 0", ready); else n_pass++;
        n_checks++; if (write_addr !== '0) $display("FAIL mrst_addr: got %0d expected 0", write_addr); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL mrst_state: got %0d expected 0", state_dbg); else n_pass++;
        @(negedge Clk);
        Reset_n    = 1'b1;
        data_valid = 1'b1;
        rdy_seen   = 0;
        for (int i = 0; i < 10; i++) begin
            data_in = PIX_W'($urandom);
            @(negedge Clk);
            if (ready) rdy_seen++;
        end
        data_valid = 1'b0;
        n_checks++; if (wr_cnt != 50) $display("FAIL mrst_writes: got %0d expected 50", wr_cnt); else n_pass++;
        n_checks++; if (done_cnt != 0) $display("FAIL mrst_done: got %0d expected 0", done_cnt); else n_pass++;
        n_checks++; if (rdy_seen != 0) $display("FAIL mrst_ready_after: got %0d cycles expected 0", rdy_seen); else n_pass++;
    endtask

    task automatic test_idle_done_data();
        int cycles, acc;
        int rdy_seen;
        int busy_seen;
        clear_sb();
        drive_load(1, 0, 0, 1'b0, NPIX, cycles, acc);
        // this cycle is the DONE state: start and data here must be ignored
        start      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hA5;
        rdy_seen   = 0;
        busy_seen  = 0;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ready) rdy_seen++;
            if (busy) busy_seen++;
            data_in = PIX_W'($urandom);
            @(negedge Clk);
        end
        data_valid = 1'b0;
        n_checks++; if (wr_cnt != NPIX) $display("FAIL idl_writes: got %0d expected %0d", wr_cnt, NPIX); else n_pass++;
        n_checks++; if (rdy_seen != 0) $display("FAIL idl_ready: got %0d cycles expected 0", rdy_seen); else n_pass++;
        n_checks++; if (busy_seen != 0) $display("FAIL idl_busy: got %0d cycles expected 0", busy_seen); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL idl_done_count: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    initial begin
        clear_sb();
        model_last_cyc = 0;
        test_reset();
        test_frame0_stream();
        test_frame2_rows();
        test_toggle_valid();
        test_abort();
        test_start_ignored();
        test_reset_mid_load();
        test_idle_done_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
